// File: rtl/decode_stage_if.sv
// Bus between the decode stage and its neighbours: the instruction and writeback inputs, plus the decoded control and operands.
// No storage here; it only groups signals, so it adds no latency.
// No flow control: the pipeline drives a new instruction every cycle.
`ifndef BITS_REGFILE
`define BITS_REGFILE 5
`endif

interface decode_stage_if #(
    parameter int AddrSize = 32
);
    // Instruction from fetch and the writeback port
    logic [AddrSize-1:0]      instruction_i;
    logic [`BITS_REGFILE-1:0] destination_i;
    logic [AddrSize-1:0]      datareg_i;
    logic                     wreg_i;

    // Decoded control and operands sent to execute
    logic                     wreg_o;
    logic                     m2reg_o;
    logic                     wmem_o;
    logic [3:0]               aluc_o;
    logic                     aluimm_o;
    logic [`BITS_REGFILE-1:0] destination_o;
    logic [AddrSize-1:0]      op1_o;
    logic [AddrSize-1:0]      op2_o;
    logic [AddrSize-1:0]      extendedimm_o;

    // Upstream side: drives the instruction and writeback, and receives the decode results
    modport master (
        output instruction_i, destination_i, datareg_i, wreg_i,
        input  wreg_o, m2reg_o, wmem_o, aluc_o, aluimm_o,
               destination_o, op1_o, op2_o, extendedimm_o
    );

    // Decode stage side
    modport slave (
        input  instruction_i, destination_i, datareg_i, wreg_i,
        output wreg_o, m2reg_o, wmem_o, aluc_o, aluimm_o,
               destination_o, op1_o, op2_o, extendedimm_o
    );
endinterface

// File: rtl/decode_stage.sv
// MIPS-subset decode and operand fetch: a 32-entry register file plus combinational control decode.
// Zero-cycle decode. A writeback reaches reads in the same cycle through the bypass, and is stored at the next edge.
// No backpressure: the stage consumes one instruction per cycle.
`ifndef BITS_REGFILE
`define BITS_REGFILE 5
`endif

module decode_stage #(
    parameter int AddrSize = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    decode_stage_if.slave        bus
);
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_LUI = 4'd8;

    localparam int NumRegs = 1 << `BITS_REGFILE;

    logic [AddrSize-1:0] regs [NumRegs];

    logic [5:0]               op;
    logic [5:0]               funct;
    logic [`BITS_REGFILE-1:0] rs;
    logic [`BITS_REGFILE-1:0] rt;
    logic [`BITS_REGFILE-1:0] rd;
    logic [4:0]               shamt;
    logic [15:0]              imm;

    assign op    = bus.instruction_i[31:26];
    assign rs    = bus.instruction_i[25:21];
    assign rt    = bus.instruction_i[20:16];
    assign rd    = bus.instruction_i[15:11];
    assign shamt = bus.instruction_i[10:6];
    assign funct = bus.instruction_i[5:0];
    assign imm   = bus.instruction_i[15:0];

    // Register file: reset clears it asynchronously; r0 is never written
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
        end else if (bus.wreg_i && bus.destination_i != '0) begin
            regs[bus.destination_i] <= bus.datareg_i;
        end
    end

    // Read port with r0 hardwired to zero and a same-cycle writeback bypass
    function automatic logic [AddrSize-1:0] read_reg(input logic [`BITS_REGFILE-1:0] idx);
        if (idx == '0)
            return '0;
        else if (bus.wreg_i && bus.destination_i == idx)
            return bus.datareg_i;
        else
            return regs[idx];
    endfunction

    // Decode the control fields and select the operands. Every output is held at zero during reset
    always_comb begin
        logic is_shift;
        is_shift          = 1'b0;
        bus.wreg_o        = 1'b0;
        bus.m2reg_o       = 1'b0;
        bus.wmem_o        = 1'b0;
        bus.aluc_o        = ALU_ADD;
        bus.aluimm_o      = 1'b0;
        bus.destination_o = '0;
        bus.extendedimm_o = {{(AddrSize-16){imm[15]}}, imm};

        case (op)
            6'h00: begin
                // Unknown funct codes leave every control output at zero (NOP)
                bus.wreg_o        = 1'b1;
                bus.destination_o = rd;
                case (funct)
                    6'h20: bus.aluc_o = ALU_ADD;
                    6'h22: bus.aluc_o = ALU_SUB;
                    6'h24: bus.aluc_o = ALU_AND;
                    6'h25: bus.aluc_o = ALU_OR;
                    6'h26: bus.aluc_o = ALU_XOR;
                    6'h00: begin bus.aluc_o = ALU_SLL; is_shift = 1'b1; end
                    6'h02: begin bus.aluc_o = ALU_SRL; is_shift = 1'b1; end
                    6'h03: begin bus.aluc_o = ALU_SRA; is_shift = 1'b1; end
                    default: begin
                        bus.wreg_o        = 1'b0;
                        bus.destination_o = '0;
                    end
                endcase
                if (is_shift) begin
                    bus.aluimm_o      = 1'b1;
                    bus.extendedimm_o = {{(AddrSize-5){1'b0}}, shamt};
                end
            end
            6'h08: begin
                bus.wreg_o = 1'b1; bus.aluimm_o = 1'b1; bus.destination_o = rt;
                bus.aluc_o = ALU_ADD;
            end
            6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                bus.wreg_o = 1'b1; bus.aluimm_o = 1'b1; bus.destination_o = rt;
                bus.extendedimm_o = {{(AddrSize-16){1'b0}}, imm};
                case (op[1:0])
                    2'b00:   bus.aluc_o = ALU_AND;
                    2'b01:   bus.aluc_o = ALU_OR;
                    2'b10:   bus.aluc_o = ALU_XOR;
                    default: bus.aluc_o = ALU_LUI;
                endcase
            end
            6'h23: begin
                bus.wreg_o = 1'b1; bus.m2reg_o = 1'b1; bus.aluimm_o = 1'b1;
                bus.destination_o = rt; bus.aluc_o = ALU_ADD;
            end
            6'h2B: begin
                bus.wmem_o = 1'b1; bus.aluimm_o = 1'b1;
                bus.destination_o = rt; bus.aluc_o = ALU_ADD;
            end
            default: ;
        endcase

        // Shifts take their source operand from rt rather than rs
        bus.op1_o = is_shift ? read_reg(rt) : read_reg(rs);
        bus.op2_o = read_reg(rt);

        if (rst_i) begin
            bus.wreg_o        = 1'b0;
            bus.m2reg_o       = 1'b0;
            bus.wmem_o        = 1'b0;
            bus.aluc_o        = '0;
            bus.aluimm_o      = 1'b0;
            bus.destination_o = '0;
            bus.op1_o         = '0;
            bus.op2_o         = '0;
            bus.extendedimm_o = '0;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: vectors push their expected decode to a scoreboard, and each entry is popped and checked once outputs settle.
// The decode itself is combinational; register writes take effect on clock edges.
// No backpressure is involved.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    decode_stage_if #(.AddrSize(32)) bus ();

    decode_stage #(.AddrSize(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        string       name;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [3:0]  aluc;
        logic        aluimm;
        logic [4:0]  dest;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] ext;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input string n, input logic w, input logic m, input logic wm,
                                input logic [3:0] a, input logic ai, input logic [4:0] d,
                                input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] e);
        exp_t r;
        r.name = n; r.wreg = w; r.m2reg = m; r.wmem = wm; r.aluc = a; r.aluimm = ai;
        r.dest = d; r.op1 = o1; r.op2 = o2; r.ext = e;
        return r;
    endfunction

    // Pop the oldest expectation and compare it against the settled DUT outputs
    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_empty: got no expectation, required one queued");
        end else begin
            e = sb.pop_front();
            check_val({e.name, ".wreg"},   32'(bus.wreg_o),        32'(e.wreg));
            check_val({e.name, ".m2reg"},  32'(bus.m2reg_o),       32'(e.m2reg));
            check_val({e.name, ".wmem"},   32'(bus.wmem_o),        32'(e.wmem));
            check_val({e.name, ".aluc"},   32'(bus.aluc_o),        32'(e.aluc));
            check_val({e.name, ".aluimm"}, 32'(bus.aluimm_o),      32'(e.aluimm));
            check_val({e.name, ".dest"},   32'(bus.destination_o), 32'(e.dest));
            check_val({e.name, ".op1"},    bus.op1_o,              e.op1);
            check_val({e.name, ".op2"},    bus.op2_o,              e.op2);
            check_val({e.name, ".ext"},    bus.extendedimm_o,      e.ext);
        end
    endtask

    task automatic apply(input logic [31:0] instr, input exp_t e);
        bus.instruction_i = instr;
        sb.push_back(e);
        #2;
        compare_out();
    endtask

    // Step to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] d, input logic [31:0] v);
        bus.wreg_i = 1'b1; bus.destination_i = d; bus.datareg_i = v;
        tick();
        bus.wreg_i = 1'b0;
    endtask

    exp_t zero_e;

    initial begin
        zero_e = mk("rst", 0, 0, 0, 4'd0, 0, 5'd0, 32'h0, 32'h0, 32'h0);

        // Reset with a pending write to r3; every output must be zero
        bus.wreg_i = 1'b1; bus.destination_i = 5'd3; bus.datareg_i = 32'h0000_AAAA;
        #1;
        apply(32'h2008_0005, zero_e);
        tick();
        tick();
        bus.wreg_i = 1'b0;
        rst = 1'b0;

        // r3 must still be clear after reset; the write during reset was dropped
        apply(32'h0060_0020, mk("post_rst", 1, 0, 0, 4'd0, 0, 5'd0, 32'h0, 32'h0, 32'h20));
        apply(32'h2008_0005, mk("addi_r8", 1, 0, 0, 4'd0, 1, 5'd8, 32'h0, 32'h0, 32'h5));

        // Same-cycle bypass, then the stored value after the edge
        bus.wreg_i = 1'b1; bus.destination_i = 5'd3; bus.datareg_i = 32'hDEAD_BEEF;
        apply(32'h0060_0020, mk("bypass", 1, 0, 0, 4'd0, 0, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h20));
        tick();
        bus.wreg_i = 1'b0;
        apply(32'h0060_0020, mk("stored", 1, 0, 0, 4'd0, 0, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h20));

        // r0 ignores writes, including through the bypass
        bus.wreg_i = 1'b1; bus.destination_i = 5'd0; bus.datareg_i = 32'h0000_1234;
        apply(32'h0000_0020, mk("r0_byp", 1, 0, 0, 4'd0, 0, 5'd0, 32'h0, 32'h0, 32'h20));
        tick();
        bus.wreg_i = 1'b0;
        apply(32'h0000_0020, mk("r0_wr", 1, 0, 0, 4'd0, 0, 5'd0, 32'h0, 32'h0, 32'h20));

        write_reg(5'd1, 32'h7);
        write_reg(5'd2, 32'h55);

        apply(32'h2022_FFFF, mk("addi",   1, 0, 0, 4'd0, 1, 5'd2, 32'h7,  32'h55, 32'hFFFF_FFFF));
        apply(32'h8C24_0008, mk("lw",     1, 1, 0, 4'd0, 1, 5'd4, 32'h7,  32'h0,  32'h8));
        apply(32'hAC24_0008, mk("sw",     0, 0, 1, 4'd0, 1, 5'd4, 32'h7,  32'h0,  32'h8));
        apply(32'h0022_2822, mk("sub",    1, 0, 0, 4'd1, 0, 5'd5, 32'h7,  32'h55, 32'h2822));
        apply(32'h3406_8000, mk("ori",    1, 0, 0, 4'd3, 1, 5'd6, 32'h0,  32'h0,  32'h8000));
        apply(32'hFC22_FFFF, mk("ill_op", 0, 0, 0, 4'd0, 0, 5'd0, 32'h7,  32'h55, 32'hFFFF_FFFF));
        apply(32'h0022_283F, mk("ill_fn", 0, 0, 0, 4'd0, 0, 5'd0, 32'h7,  32'h55, 32'h283F));
        apply(32'h0002_38C3, mk("sra",    1, 0, 0, 4'd7, 1, 5'd7, 32'h55, 32'h55, 32'h3));
        apply(32'h0002_3882, mk("srl",    1, 0, 0, 4'd6, 1, 5'd7, 32'h55, 32'h55, 32'h2));
        apply(32'h0000_0000, mk("sll0",   1, 0, 0, 4'd5, 1, 5'd0, 32'h0,  32'h0,  32'h0));
        apply(32'h3C09_ABCD, mk("lui",    1, 0, 0, 4'd8, 1, 5'd9, 32'h0,  32'h0,  32'hABCD));
        apply(32'h3023_F000, mk("andi",   1, 0, 0, 4'd2, 1, 5'd3, 32'h7,  32'hDEAD_BEEF, 32'hF000));
        apply(32'h3822_0001, mk("xori",   1, 0, 0, 4'd4, 1, 5'd2, 32'h7,  32'h55, 32'h1));
        apply(32'h0022_2824, mk("and",    1, 0, 0, 4'd2, 0, 5'd5, 32'h7,  32'h55, 32'h2824));
        apply(32'h0022_2825, mk("or",     1, 0, 0, 4'd3, 0, 5'd5, 32'h7,  32'h55, 32'h2825));
        apply(32'h0022_2826, mk("xor",    1, 0, 0, 4'd4, 0, 5'd5, 32'h7,  32'h55, 32'h2826));

        // Reset asserted in the middle of a write cycle: the write is lost and r1 is cleared at once
        bus.wreg_i = 1'b1; bus.destination_i = 5'd1; bus.datareg_i = 32'h99;
        bus.instruction_i = 32'h0020_0020;
        #2;
        rst = 1'b1;
        apply(32'h0020_0020, zero_e);
        tick();
        rst = 1'b0;
        bus.wreg_i = 1'b0;
        apply(32'h0020_0020, mk("mid_rst", 1, 0, 0, 4'd0, 0, 5'd0, 32'h0, 32'h0, 32'h20));

        if (sb.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_left: got %0d entries, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode and operand-fetch stage of the 5-stage MIPS-subset pipeline; sits between fetch and execute.
- Holds the 32-entry register file, written back from the writeback stage.
- Combinationally decodes the current instruction into execute/memory/writeback control, destination register, two register operands and an extended immediate.

Parameters:
- AddrSize, 32, data/instruction width. Only 32 is supported because instruction fields are fixed.
- `BITS_REGFILE (define in defines.vh), 5, register index width. Gives 2^5 = 32 registers.

Ports:
- clk_i, input, 1, clock. Register file writes on the rising edge.
- rst_i, input, 1, asynchronous active-high reset.
- instruction_i, input, AddrSize, instruction word being decoded.
- destination_i, input, `BITS_REGFILE, writeback register index.
- datareg_i, input, AddrSize, writeback data.
- wreg_i, input, 1, writeback write enable.
- wreg_o, output, 1, instruction writes a register.
- m2reg_o, output, 1, writeback source is memory (load).
- wmem_o, output, 1, instruction writes memory (store).
- aluc_o, output, 4, ALU operation code.
- aluimm_o, output, 1, ALU second operand is extendedimm_o instead of op2_o.
- destination_o, output, `BITS_REGFILE, destination register index.
- op1_o, output, AddrSize, first register operand.
- op2_o, output, AddrSize, second register operand.
- extendedimm_o, output, AddrSize, extended immediate or shift amount.

Behaviour:
- Instruction fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0].
- Register file: 32 x AddrSize.
  - Write on posedge clk_i when wreg_i=1 and destination_i!=0.
  - Register 0 always reads 0; writes to it are ignored.
- Reads are combinational with write-through bypass: if wreg_i=1, destination_i!=0 and destination_i equals the read index, the read returns datareg_i in the same cycle.
- Reset:
  - rst_i=1 clears all registers immediately, without waiting for a clock edge.
  - While rst_i=1, every output is forced to 0.
  - Writes are blocked while rst_i=1.
- All outputs are combinational from instruction_i and register state. Decode latency is 0 cycles; written data is visible to reads from the next cycle, and in the same cycle via the bypass.
- Default operand mapping:
  - op1_o = reg[rs]; op2_o = reg[rt].
  - Exception for shifts: op1_o = reg[rt].
- aluc_o encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, LUI=8.
- R-type instructions (op=0x00): wreg=1, destination=rd, m2reg=0, wmem=0.
  - funct 0x20 add -> ADD, aluimm=0.
  - funct 0x22 sub -> SUB, aluimm=0.
  - funct 0x24 and -> AND, aluimm=0.
  - funct 0x25 or -> OR, aluimm=0.
  - funct 0x26 xor -> XOR, aluimm=0.
  - funct 0x00 sll -> SLL, aluimm=1, extendedimm = zero-extended shamt.
  - funct 0x02 srl -> SRL, aluimm=1, extendedimm = zero-extended shamt.
  - funct 0x03 sra -> SRA, aluimm=1, extendedimm = zero-extended shamt.
- I-type instructions: destination=rt, aluimm=1.
  - addi 0x08 -> ADD, wreg=1, sign-extended imm.
  - andi 0x0C -> AND, wreg=1, zero-extended imm.
  - ori 0x0D -> OR, wreg=1, zero-extended imm.
  - xori 0x0E -> XOR, wreg=1, zero-extended imm.
  - lui 0x0F -> LUI, wreg=1, zero-extended imm.
  - lw 0x23 -> ADD, wreg=1, m2reg=1, sign-extended imm.
  - sw 0x2B -> ADD, wmem=1, wreg=0, sign-extended imm.
- Unsupported op/funct is treated as a NOP:
  - wreg, m2reg, wmem, aluimm, aluc and destination all 0.
  - op1_o, op2_o and extendedimm_o still follow the default field mapping (sign-extended imm).
- Instruction 0x00000000 decodes as sll r0,r0,0, which is effectively a NOP because the destination is r0.
- destination_o for an instruction targeting r0 is still reported as 0, with wreg_o as decoded.
- Simultaneous events:
  - Write and read of the same register in one cycle: bypass value is returned.
  - Reset asserted mid-write: the write is dropped.

Test Plan:
- Reset: assert rst_i with instruction_i=0x2008_0005 -> all outputs 0. Release reset -> op1_o=0 (register file cleared).
- Writeback and bypass: wreg_i=1, destination_i=3, datareg_i=0xDEADBEEF, instruction_i=0x0060_0020 (add r0,r3,r0) -> op1_o=0xDEADBEEF in the same cycle. After the clock edge with wreg_i=0 -> op1_o remains 0xDEADBEEF.
- r0 protection: write 0x1234 to destination_i=0 -> any read of r0 returns 0.
- addi r2,r1,-1 (0x2022_FFFF) with r1=7 -> wreg=1, aluimm=1, aluc=0, destination=2, op1=7, extendedimm=0xFFFF_FFFF.
- lw r4,8(r1) (0x8C24_0008) -> wreg=1, m2reg=1, extendedimm=8. sw r4,8(r1) (0xAC24_0008) -> wmem=1, wreg=0.
- sub r5,r1,r2 (0x0022_2822) -> aluc=1, destination=5, aluimm=0. ori r6,r0,0x8000 (0x3406_8000) -> extendedimm=0x0000_8000, aluc=3. Illegal op 0x3F -> all control outputs 0.
